// File: rtl/el_dr_sink_if.sv
// Link and read-side bundle of el_dr_sink: dual-rail input with ack, and the
// valid/ready FIFO head with status outputs.
interface el_dr_sink_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RAIL_NUM = 2,
  parameter int unsigned DEPTH    = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [RAIL_NUM*WIDTH-1:0] in;
  logic                      ack_o;
  logic [WIDTH-1:0]          data_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [LVL_W-1:0]          level_o;
  logic [15:0]               word_cnt_o;
  logic                      err_o;

  modport master (
    output in, ready_i,
    input  ack_o, data_o, valid_o, level_o, word_cnt_o, err_o
  );

  modport slave (
    input  in, ready_i,
    output ack_o, data_o, valid_o, level_o, word_cnt_o, err_o
  );
endinterface

// File: rtl/el_dr_sink.sv
// Clocked sink for a dual-rail 4-phase link: synchronises the rails, acks each
// codeword and spacer, and buffers decoded words in a first-word-fall-through FIFO.
module el_dr_sink #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned RAIL_NUM    = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  el_dr_sink_if.slave bus
);
  localparam int unsigned RAIL_W = RAIL_NUM * WIDTH;
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {S_WAIT_DATA, S_WAIT_NULL} state_e;

  logic [RAIL_W-1:0] sync_q [SYNC_STAGES];
  logic [RAIL_W-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0]  mem_q  [DEPTH];
  logic [WIDTH-1:0]  mem_d  [DEPTH];

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic [WIDTH-1:0]  t_rail_c, f_rail_c;
  logic              complete_c, spacer_c, illegal_c;
  logic              pop_c, push_c, can_push_c;

  // Rail synchroniser chain
  always_comb begin
    sync_d[0] = bus.in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end

  // Split synced pairs into true/false rails and classify the codeword
  always_comb begin
    t_rail_c = '0;
    f_rail_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_rail_c[i] = sync_q[SYNC_STAGES-1][2*i+1];
      f_rail_c[i] = sync_q[SYNC_STAGES-1][2*i];
    end
    complete_c = &(t_rail_c ^ f_rail_c);
    spacer_c   = ~|sync_q[SYNC_STAGES-1];
    illegal_c  = |(t_rail_c & f_rail_c);
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    err_d      = err_q | illegal_c;
    word_cnt_d = word_cnt_q;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    push_c     = 1'b0;
    pop_c      = valid_q & bus.ready_i;
    // A full FIFO still accepts when its head leaves on the same edge
    can_push_c = (level_q < LVL_W'(DEPTH)) | pop_c;

    case (state_q)
      S_WAIT_DATA: begin
        if (!illegal_c && complete_c && can_push_c) begin
          push_c     = 1'b1;
          ack_d      = 1'b1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          state_d    = S_WAIT_NULL;
        end
      end
      S_WAIT_NULL: begin
        if (spacer_c) begin
          ack_d   = 1'b0;
          state_d = S_WAIT_DATA;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = S_WAIT_DATA;
      end
    endcase

    if (push_c) begin
      mem_d[wptr_q] = t_rail_c;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop_c) rptr_d = rptr_q + PTR_W'(1);

    level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    valid_d = (level_d != '0);
    data_d  = mem_d[rptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q    <= S_WAIT_DATA;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      mem_q      <= mem_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.level_o    = level_q;
  assign bus.word_cnt_o = word_cnt_q;
  assign bus.err_o      = err_q;
endmodule
